// File: rtl/lfa_pkg.sv
// lfa_pkg: shared FSM encoding, ADC frame sizes, default channels and helpers
package lfa_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_GAP, ST_SHIFT} state_t;
    localparam int ADC_BITS    = 12;
    localparam int FRAME_SCLKS = 16;
    localparam logic [2:0] DEF_CH_LEFT   = 3'd3;
    localparam logic [2:0] DEF_CH_MIDDLE = 3'd5;
    localparam logic [2:0] DEF_CH_RIGHT  = 3'd7;
    function automatic logic [1:0] seq_next(input logic [1:0] i);
        return (i == 2'd2) ? 2'd0 : i + 2'd1;
    endfunction
    // control word is 0,0,ADD2,ADD1,ADD0 then zeros, indexed by SCLK period - 1
    function automatic logic ctrl_bit(input logic [3:0] b, input logic [2:0] addr);
        return (b == 4'd2) ? addr[2] : (b == 4'd3) ? addr[1] : (b == 4'd4) ? addr[0] : 1'b0;
    endfunction
endpackage

// File: rtl/adc128_spi_frame.sv
// adc128_spi_frame: one 16-SCLK ADC128S022 transfer with SCLK = clk/2
module adc128_spi_frame
    import lfa_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic [2:0]          addr_i,
    input  logic                sdo_i,
    output logic                cs_n_o,
    output logic                sck_o,
    output logic                din_o,
    output logic                done_o,
    output logic [ADC_BITS-1:0] data_o
);
    localparam logic [4:0] LAST_EDGE = 5'(2 * FRAME_SCLKS - 1);
    logic                active_q, cs_n_q, sck_q, din_q;
    logic [4:0]          cnt_q, cnt_d;
    logic [2:0]          addr_q;
    logic [ADC_BITS-1:0] sr_q;
    assign cnt_d  = cnt_q + 5'd1;
    assign done_o = active_q && cnt_q == LAST_EDGE;
    assign cs_n_o = cs_n_q;
    assign sck_o  = sck_q;
    assign din_o  = din_q;
    assign data_o = sr_q;
    // the four leading zeros fall off the top of the 12-bit register by the last edge
    always_ff @(posedge clk) begin
        if (rst) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            cs_n_q   <= 1'b1;
            sck_q    <= 1'b1;
            din_q    <= 1'b0;
            addr_q   <= '0;
            sr_q     <= '0;
        end else if (done_o) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            cs_n_q   <= 1'b1;
            sck_q    <= 1'b1;
            din_q    <= 1'b0;
        end else if (active_q) begin
            cnt_q <= cnt_d;
            sck_q <= cnt_d[0];
            if (!cnt_d[0]) din_q <= ctrl_bit(cnt_d[4:1], addr_q);
            else sr_q <= {sr_q[ADC_BITS-2:0], sdo_i};
        end else if (start_i) begin
            active_q <= 1'b1;
            cnt_q    <= '0;
            cs_n_q   <= 1'b0;
            sck_q    <= 1'b0;
            din_q    <= ctrl_bit(4'd0, addr_i);
            addr_q   <= addr_i;
        end
    end
endmodule

// File: rtl/lfa_adc_sampler.sv
// lfa_adc_sampler: round-robin left/middle/right ADC sampling with sweep strobe
module lfa_adc_sampler
    import lfa_pkg::*;
#(
    parameter logic [2:0] CH_LEFT    = DEF_CH_LEFT,
    parameter logic [2:0] CH_MIDDLE  = DEF_CH_MIDDLE,
    parameter logic [2:0] CH_RIGHT   = DEF_CH_RIGHT,
    parameter int         GAP_CYCLES = 2
) (
    input  logic                clk_3125KHz,
    input  logic                reset,
    input  logic                run_en,
    input  logic                adc_dout,
    output logic                adc_cs_n,
    output logic                adc_sck,
    output logic                adc_din,
    output logic [ADC_BITS-1:0] left,
    output logic [ADC_BITS-1:0] middle,
    output logic [ADC_BITS-1:0] right,
    output logic                sample_valid
);
    localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);
    state_t              state_q;
    logic [7:0]          gap_cnt_q;
    logic [1:0]          idx_q, sel_d;
    logic                discard_q, start_d, frame_done, valid_q;
    logic [2:0]          addr_d;
    logic [ADC_BITS-1:0] frame_data, left_q, middle_q, right_q;
    // a discard frame re-addresses the current slot so the ADC pipeline refills
    assign sel_d   = discard_q ? idx_q : seq_next(idx_q);
    assign addr_d  = (sel_d == 2'd0) ? CH_LEFT : (sel_d == 2'd1) ? CH_MIDDLE : CH_RIGHT;
    assign start_d = state_q == ST_GAP && gap_cnt_q == GAP_LAST;
    assign left         = left_q;
    assign middle       = middle_q;
    assign right        = right_q;
    assign sample_valid = valid_q;
    adc128_spi_frame u_frame (
        .clk     (clk_3125KHz),
        .rst     (reset),
        .start_i (start_d),
        .addr_i  (addr_d),
        .sdo_i   (adc_dout),
        .cs_n_o  (adc_cs_n),
        .sck_o   (adc_sck),
        .din_o   (adc_din),
        .done_o  (frame_done),
        .data_o  (frame_data)
    );
    always_ff @(posedge clk_3125KHz) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            gap_cnt_q <= '0;
            idx_q     <= '0;
            discard_q <= 1'b1;
            left_q    <= '0;
            middle_q  <= '0;
            right_q   <= '0;
            valid_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: if (run_en) begin
                    state_q   <= ST_GAP;
                    gap_cnt_q <= '0;
                end
                ST_GAP: begin
                    gap_cnt_q <= gap_cnt_q + 8'd1;
                    if (start_d) state_q <= ST_SHIFT;
                end
                ST_SHIFT: if (frame_done) begin
                    state_q   <= run_en ? ST_GAP : ST_IDLE;
                    gap_cnt_q <= '0;
                    discard_q <= !run_en;
                    idx_q     <= run_en ? sel_d : 2'd0;
                    if (!discard_q) begin
                        if (idx_q == 2'd0) left_q <= frame_data;
                        if (idx_q == 2'd1) middle_q <= frame_data;
                        if (idx_q == 2'd2) right_q <= frame_data;
                        valid_q <= idx_q == 2'd2;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end
endmodule
